// File: rtl/hc_mmio_initiator_if.sv
// Command, MMIO request/response and result bundle for the HardCloud MMIO initiator.
interface hc_mmio_initiator_if #(
  parameter int unsigned TID_W = 9
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 16;

  // Command side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_len64;
  logic [DATA_W-1:0] cmd_data;

  // MMIO request side
  logic              mmio_rd_valid;
  logic              mmio_wr_valid;
  logic [ADDR_W-1:0] mmio_addr;
  logic [1:0]        mmio_len;
  logic [TID_W-1:0]  mmio_tid;
  logic [DATA_W-1:0] mmio_data;

  // MMIO read response side
  logic              rsp_valid;
  logic [TID_W-1:0]  rsp_tid;
  logic [DATA_W-1:0] rsp_data;

  // Read result side
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_error;
  logic [CNT_W-1:0]  stray_cnt;

  // Initiator view
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len64, cmd_data,
    output cmd_ready,
    output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_data,
    input  rsp_valid, rsp_tid, rsp_data,
    output res_valid, res_data, res_error, stray_cnt,
    input  res_ready
  );

  // Host / responder view
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len64, cmd_data,
    input  cmd_ready,
    input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_data,
    output rsp_valid, rsp_tid, rsp_data,
    input  res_valid, res_data, res_error, stray_cnt,
    output res_ready
  );

endinterface

// File: rtl/hc_mmio_initiator.sv
// Host-side MMIO requester: issues one CSR read/write at a time, matches the read
// response by tid, fails a read on timeout and counts responses nobody asked for.
module hc_mmio_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TID_W          = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  hc_mmio_initiator_if.master bus
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TMR_W  = 16;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          len_q, len_d;
  logic [TID_W-1:0]    tid_q, tid_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_error_q, res_error_d;
  logic [CNT_W-1:0]    stray_q, stray_d;
  logic [TID_W-1:0]    next_tid_q, next_tid_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic cmd_fire_c;
  logic rsp_match_c;
  logic timeout_c;

  // Handshake and response qualification
  assign cmd_fire_c  = cmd_ready_q & bus.cmd_valid;
  assign rsp_match_c = (state_q == S_WAIT) & bus.rsp_valid & (bus.rsp_tid == tid_q);
  assign timeout_c   = (state_q == S_WAIT) & (timer_q == TMR_LAST);

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      tid_q       <= '0;
      wdata_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
      stray_q     <= '0;
      next_tid_q  <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      wr_valid_q  <= wr_valid_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      tid_q       <= tid_d;
      wdata_q     <= wdata_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
      stray_q     <= stray_d;
      next_tid_q  <= next_tid_d;
      timer_q     <= timer_d;
    end
  end

  // Next-state decode; a match beats a coincident timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_fire_c) state_d = S_ISSUE;
      S_ISSUE: state_d = wr_valid_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (rsp_match_c || timeout_c) state_d = S_DONE;
      S_DONE:  if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping counters
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    res_valid_d = (state_d == S_DONE);
    rd_valid_d  = 1'b0;
    wr_valid_d  = 1'b0;
    addr_d      = addr_q;
    len_d       = len_q;
    tid_d       = tid_q;
    wdata_d     = wdata_q;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    next_tid_d  = next_tid_q;
    stray_d     = stray_q;
    timer_d     = '0;

    // Latch the accepted command into the request registers; strobe fires next cycle
    if (state_q == S_IDLE && cmd_fire_c) begin
      rd_valid_d = ~bus.cmd_write;
      wr_valid_d = bus.cmd_write;
      addr_d     = bus.cmd_addr;
      len_d      = {1'b0, bus.cmd_len64};
      if (bus.cmd_write) begin
        tid_d   = '0;
        wdata_d = bus.cmd_len64 ? bus.cmd_data : {32'h0, bus.cmd_data[31:0]};
      end else begin
        tid_d      = next_tid_q;
        wdata_d    = '0;
        next_tid_d = next_tid_q + TID_W'(1);
      end
    end

    // Response wait: timer runs only while staying in WAIT
    if (state_q == S_WAIT) begin
      if (state_d == S_WAIT) begin
        timer_d = timer_q + TMR_W'(1);
      end
      if (rsp_match_c) begin
        res_data_d  = bus.rsp_data;
        res_error_d = 1'b0;
      end else if (timeout_c) begin
        res_data_d  = '0;
        res_error_d = 1'b1;
      end
    end

    // Any response not consumed as the match is stray
    if (bus.rsp_valid && !rsp_match_c && stray_q != CNT_MAX) begin
      stray_d = stray_q + CNT_W'(1);
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.mmio_rd_valid = rd_valid_q;
  assign bus.mmio_wr_valid = wr_valid_q;
  assign bus.mmio_addr     = addr_q;
  assign bus.mmio_len      = len_q;
  assign bus.mmio_tid      = tid_q;
  assign bus.mmio_data     = wdata_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_data      = res_data_q;
  assign bus.res_error     = res_error_q;
  assign bus.stray_cnt     = stray_q;

endmodule

// File: tb/tb_hc_mmio_initiator.sv
// Bench for hc_mmio_initiator: scoreboarded requests/results, a 2-cycle CSR responder
// model, a vector table and hand-written timeout / stray / reset sequences.
module tb_hc_mmio_initiator;

  localparam int unsigned TID_W   = 9;
  localparam int unsigned TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hc_mmio_initiator_if #(.TID_W(TID_W)) bus ();

  hc_mmio_initiator #(.TIMEOUT_CYCLES(TIMEOUT), .TID_W(TID_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic             wr;
    logic [15:0]      addr;
    logic [1:0]       len;
    logic [TID_W-1:0] tid;
    logic [63:0]      data;
  } req_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } res_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic        len64;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
  } vec_t;

  req_t req_q[$];
  res_t res_q[$];
  vec_t vecs[8];

  int n_checks = 0;
  int n_fail   = 0;

  logic [TID_W-1:0] exp_tid;
  logic [15:0]      exp_stray;

  // Responder control: 0 = auto 2-cycle, 1 = silent, 2 = manual
  int               rsp_mode;
  logic             man_valid;
  logic [TID_W-1:0] man_tid;
  logic [63:0]      man_data;

  function automatic logic [63:0] csr_model(input logic [15:0] a);
    if (a == 16'h0000) return 64'h1000_0000_0400_0000;
    return {a, 16'hC0DE, ~a, a ^ 16'h5A5A};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Responder model: answers a read strobe two cycles later with the model data
  initial begin : responder
    int               pend_cnt;
    logic [TID_W-1:0] pend_tid;
    logic [63:0]      pend_data;
    pend_cnt      = 0;
    pend_tid      = '0;
    pend_data     = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_tid   = '0;
    bus.rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_mode == 2) begin
        pend_cnt      = 0;
        bus.rsp_valid = man_valid;
        bus.rsp_tid   = man_tid;
        bus.rsp_data  = man_data;
      end else begin
        bus.rsp_valid = 1'b0;
        if (rsp_mode == 0 && reset_n) begin
          if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
              bus.rsp_valid = 1'b1;
              bus.rsp_tid   = pend_tid;
              bus.rsp_data  = pend_data;
            end
          end
          if (bus.mmio_rd_valid) begin
            pend_cnt  = 2;
            pend_tid  = bus.mmio_tid;
            pend_data = csr_model(bus.mmio_addr);
          end
        end else begin
          pend_cnt = 0;
        end
      end
    end
  end

  // Scoreboard monitor: pops expected requests on strobes and expected results on handshakes
  initial begin : monitor
    req_t r;
    res_t s;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n) begin
        if (bus.mmio_rd_valid || bus.mmio_wr_valid) begin
          if (req_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got rd=%0b wr=%0b, want none", bus.mmio_rd_valid, bus.mmio_wr_valid);
          end else begin
            r = req_q.pop_front();
            check("req_wr_valid", 64'(bus.mmio_wr_valid), 64'(r.wr));
            check("req_rd_valid", 64'(bus.mmio_rd_valid), 64'(!r.wr));
            check("req_addr", 64'(bus.mmio_addr), 64'(r.addr));
            check("req_len", 64'(bus.mmio_len), 64'(r.len));
            check("req_tid", 64'(bus.mmio_tid), 64'(r.tid));
            check("req_data", bus.mmio_data, r.data);
          end
        end
        if (bus.res_valid && bus.res_ready) begin
          if (res_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got data=0x%0h err=%0b, want none", bus.res_data, bus.res_error);
          end else begin
            s = res_q.pop_front();
            check("res_data", bus.res_data, s.data);
            check("res_error", 64'(bus.res_error), 64'(s.err));
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the strobe cycle
  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic len64,
                          input logic [63:0] data);
    req_t r;
    int   n;
    r.wr   = wr;
    r.addr = addr;
    r.len  = {1'b0, len64};
    r.tid  = wr ? '0 : exp_tid;
    r.data = wr ? (len64 ? data : {32'h0, data[31:0]}) : 64'h0;
    if (!wr) exp_tid = exp_tid + 1'b1;
    req_q.push_back(r);
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len64 = len64;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept: got cmd_ready=0 for %0d cycles, want 1", n);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic read_op(input logic [15:0] addr, input logic len64,
                         input logic [63:0] exp_data, input logic exp_err);
    res_t s;
    s.data = exp_data;
    s.err  = exp_err;
    res_q.push_back(s);
    send_cmd(1'b0, addr, len64, 64'h0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((req_q.size() != 0 || res_q.size() != 0 || !bus.cmd_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL %s: got %0d req / %0d res pending after %0d cycles, want 0", name,
               req_q.size(), res_q.size(), n);
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    req_q.delete();
    res_q.delete();
    exp_tid   = '0;
    exp_stray = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish by 500000 ns, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [TID_W-1:0] t;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len64 = 1'b0;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b1;
    rsp_mode      = 0;
    man_valid     = 1'b0;
    man_tid       = '0;
    man_data      = '0;
    exp_tid       = '0;
    exp_stray     = '0;

    vecs[0] = '{1'b0, 16'h0004, 1'b1, 64'h0,                   64'h0004_C0DE_FFFB_5A5E};
    vecs[1] = '{1'b1, 16'h0008, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'h0};
    vecs[2] = '{1'b0, 16'h0010, 1'b0, 64'h0,                   64'h0010_C0DE_FFEF_5A4A};
    vecs[3] = '{1'b1, 16'hFFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[4] = '{1'b0, 16'hFFFF, 1'b1, 64'h0,                   64'hFFFF_C0DE_0000_A5A5};
    vecs[5] = '{1'b0, 16'h1234, 1'b1, 64'h0,                   64'h1234_C0DE_EDCB_486E};
    vecs[6] = '{1'b1, 16'h0000, 1'b0, 64'h0000_0000_0000_0001, 64'h0};
    vecs[7] = '{1'b0, 16'h0000, 1'b0, 64'h0,                   64'h1000_0000_0400_0000};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'h1);
    check("rst_rd_valid", 64'(bus.mmio_rd_valid), 64'h0);
    check("rst_wr_valid", 64'(bus.mmio_wr_valid), 64'h0);
    check("rst_mmio_addr", 64'(bus.mmio_addr), 64'h0);
    check("rst_mmio_len", 64'(bus.mmio_len), 64'h0);
    check("rst_mmio_tid", 64'(bus.mmio_tid), 64'h0);
    check("rst_mmio_data", bus.mmio_data, 64'h0);
    check("rst_res_valid", 64'(bus.res_valid), 64'h0);
    check("rst_res_data", bus.res_data, 64'h0);
    check("rst_res_error", 64'(bus.res_error), 64'h0);
    check("rst_stray", 64'(bus.stray_cnt), 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Read addr 0: strobe at T+1 with tid 0, result at T+4
    read_op(16'h0000, 1'b1, 64'h1000_0000_0400_0000, 1'b0);
    check("rd0_strobe_t1", 64'(bus.mmio_rd_valid), 64'h1);
    check("rd0_tid_t1", 64'(bus.mmio_tid), 64'h0);
    check("rd0_cmd_ready_t1", 64'(bus.cmd_ready), 64'h0);
    @(negedge clk);
    check("rd0_strobe_t2", 64'(bus.mmio_rd_valid), 64'h0);
    check("rd0_res_valid_t2", 64'(bus.res_valid), 64'h0);
    @(negedge clk);
    check("rd0_res_valid_t3", 64'(bus.res_valid), 64'h0);
    @(negedge clk);
    check("rd0_res_valid_t4", 64'(bus.res_valid), 64'h1);
    check("rd0_res_data_t4", bus.res_data, 64'h1000_0000_0400_0000);
    check("rd0_res_error_t4", 64'(bus.res_error), 64'h0);
    wait_drain("rd0_drain");

    // 64-bit write: single strobe, cmd_ready back the cycle after
    send_cmd(1'b1, 16'h0020, 1'b1, 64'h0000_0001_2345_6780);
    check("wr_strobe_t1", 64'(bus.mmio_wr_valid), 64'h1);
    check("wr_len_t1", 64'(bus.mmio_len), 64'h1);
    check("wr_data_t1", bus.mmio_data, 64'h0000_0001_2345_6780);
    check("wr_tid_t1", 64'(bus.mmio_tid), 64'h0);
    check("wr_cmd_ready_t1", 64'(bus.cmd_ready), 64'h0);
    @(negedge clk);
    check("wr_strobe_t2", 64'(bus.mmio_wr_valid), 64'h0);
    check("wr_cmd_ready_t2", 64'(bus.cmd_ready), 64'h1);
    check("wr_data_held_t2", bus.mmio_data, 64'h0000_0001_2345_6780);
    wait_drain("wr_drain");

    // Vector table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) send_cmd(1'b1, vecs[i].addr, vecs[i].len64, vecs[i].wdata);
      else            read_op(vecs[i].addr, vecs[i].len64, vecs[i].exp_rdata, 1'b0);
      wait_drain("vec_drain");
    end
    check("vec_stray", 64'(bus.stray_cnt), 64'h0);

    // 513 back-to-back reads: tids 0..511 then 0
    do_reset();
    for (int i = 0; i < 513; i++) begin
      read_op(16'(i * 4), 1'b1, csr_model(16'(i * 4)), 1'b0);
    end
    wait_drain("b2b_drain");
    check("b2b_next_tid_wrapped", 64'(exp_tid), 64'h1);
    check("b2b_stray", 64'(bus.stray_cnt), 64'h0);

    // Timeout with silent responder, then a late response counts as stray
    do_reset();
    rsp_mode = 1;
    read_op(16'h0004, 1'b1, 64'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("to_waiting", 64'(bus.res_valid), 64'h0);
    end
    @(negedge clk);
    check("to_res_valid", 64'(bus.res_valid), 64'h1);
    check("to_res_error", 64'(bus.res_error), 64'h1);
    check("to_res_data", bus.res_data, 64'h0);
    rsp_mode  = 2;
    @(negedge clk);
    man_valid = 1'b1;
    man_tid   = '0;
    man_data  = 64'h0BAD_0BAD_0BAD_0BAD;
    @(negedge clk);
    man_valid = 1'b0;
    @(negedge clk);
    exp_stray = 16'd1;
    check("late_stray", 64'(bus.stray_cnt), 64'(exp_stray));
    check("late_no_result", 64'(bus.res_valid), 64'h0);
    check("late_cmd_ready", 64'(bus.cmd_ready), 64'h1);
    wait_drain("to_drain");

    // Match on the last timer cycle wins over the timeout
    t = exp_tid;
    read_op(16'h0010, 1'b1, csr_model(16'h0010), 1'b0);
    repeat (8) @(negedge clk);
    man_valid = 1'b1;
    man_tid   = t;
    man_data  = csr_model(16'h0010);
    @(negedge clk);
    man_valid = 1'b0;
    check("edge_res_valid", 64'(bus.res_valid), 64'h1);
    check("edge_res_error", 64'(bus.res_error), 64'h0);
    check("edge_res_data", bus.res_data, csr_model(16'h0010));
    wait_drain("edge_drain");
    check("edge_stray", 64'(bus.stray_cnt), 64'(exp_stray));

    // Wrong tid then right tid; result held while res_ready is low
    t = exp_tid;
    read_op(16'h1234, 1'b1, csr_model(16'h1234), 1'b0);
    bus.res_ready = 1'b0;
    @(negedge clk);
    man_valid = 1'b1;
    man_tid   = t ^ TID_W'(1);
    man_data  = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    man_tid   = t;
    man_data  = csr_model(16'h1234);
    @(negedge clk);
    man_valid = 1'b0;
    exp_stray = exp_stray + 16'd1;
    check("wt_stray", 64'(bus.stray_cnt), 64'(exp_stray));
    check("wt_res_valid", 64'(bus.res_valid), 64'h1);
    check("wt_res_data", bus.res_data, csr_model(16'h1234));
    // A response arriving in DONE is stray and must not disturb the result
    man_valid = 1'b1;
    man_tid   = t;
    man_data  = 64'h1111_2222_3333_4444;
    @(negedge clk);
    man_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_res_valid", 64'(bus.res_valid), 64'h1);
      check("hold_res_data", bus.res_data, csr_model(16'h1234));
      check("hold_res_error", 64'(bus.res_error), 64'h0);
      check("hold_cmd_ready", 64'(bus.cmd_ready), 64'h0);
    end
    exp_stray = exp_stray + 16'd1;
    check("done_stray", 64'(bus.stray_cnt), 64'(exp_stray));
    bus.res_ready = 1'b1;
    wait_drain("wt_drain");

    // Reset while waiting for a response
    rsp_mode = 1;
    read_op(16'h0004, 1'b1, 64'h0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b0;
    req_q.delete();
    res_q.delete();
    exp_tid   = '0;
    exp_stray = '0;
    #1;
    check("arst_cmd_ready", 64'(bus.cmd_ready), 64'h1);
    check("arst_rd_valid", 64'(bus.mmio_rd_valid), 64'h0);
    check("arst_res_valid", 64'(bus.res_valid), 64'h0);
    check("arst_mmio_tid", 64'(bus.mmio_tid), 64'h0);
    check("arst_stray", 64'(bus.stray_cnt), 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_hold_res_valid", 64'(bus.res_valid), 64'h0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_quiet_res", 64'(bus.res_valid), 64'h0);
      check("post_rst_quiet_rd", 64'(bus.mmio_rd_valid), 64'h0);
    end
    rsp_mode = 0;
    read_op(16'h0000, 1'b1, 64'h1000_0000_0400_0000, 1'b0);
    check("post_rst_tid", 64'(bus.mmio_tid), 64'h0);
    wait_drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
